audio_sample_pacer: RTL and testbench

Sample source for the PWM audio DAC: buffers signed stereo samples written by the CPU bus in a small FIFO and releases one sample pair per sample period. On each release it pulses `next_sample` and presents offset-binary (unsigned) `left_data`/`right_data` for the DAC to capture. It also reports FIFO level, underrun and overflow status back to the register interface.

---
 rtl/audio_sample_pacer.sv | 129 ++++++++++++
 tb/tb_audio_sample_pacer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/audio_sample_pacer.sv
// Paced stereo sample source: buffers signed sample pairs in a FIFO and releases one
// offset-binary pair per sample period with a registered strobe.
module audio_sample_pacer #(
  parameter int unsigned DIVIDER    = 650,
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned LOW_THRESH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable_i,
  input  logic                  flush_i,
  input  logic                  wr_en_i,
  input  logic [31:0]           wr_data_i,
  input  logic                  status_clr_i,
  output logic [DEPTH_LOG2:0]   fifo_level_o,
  output logic                  fifo_full_o,
  output logic                  fifo_low_o,
  output logic                  underrun_o,
  output logic                  overflow_o,
  output logic                  next_sample_o,
  output logic [15:0]           left_data_o,
  output logic [15:0]           right_data_o
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam int unsigned LevelW = DEPTH_LOG2 + 1;
  localparam logic [15:0] CntReload = 16'(DIVIDER - 1);
  localparam logic [DEPTH_LOG2:0] LevelFull = LevelW'(Depth);
  localparam logic [DEPTH_LOG2:0] LevelLow = LevelW'(LOW_THRESH);
  localparam logic [DEPTH_LOG2:0] LevelOne = LevelW'(1);
  localparam logic [DEPTH_LOG2-1:0] PtrOne = DEPTH_LOG2'(1);

  logic [15:0]           cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic [31:0]           mem_q [Depth];
  logic [15:0]           left_q, left_d, right_q, right_d;
  logic                  strobe_q, strobe_d;
  logic                  underrun_q, underrun_d, overflow_q, overflow_d;

  logic tick, empty, full, pop, push;
  logic [31:0] head;

  always_comb begin
    tick  = enable_i && (cnt_q == 16'd0);
    empty = (level_q == '0);
    full  = (level_q == LevelFull);
    head  = mem_q[rptr_q];
    // Flush wins over any same-cycle pop or write; a pop frees a slot for a write at full.
    pop   = tick && !empty && !flush_i;
    push  = wr_en_i && (!full || pop) && !flush_i;

    cnt_d = cnt_q;
    if (!enable_i || tick) begin
      cnt_d = CntReload;
    end else begin
      cnt_d = cnt_q - 16'd1;
    end

    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PtrOne;
      if (pop)  rptr_d = rptr_q + PtrOne;
      unique case ({push, pop})
        2'b10:   level_d = level_q + LevelOne;
        2'b01:   level_d = level_q - LevelOne;
        default: level_d = level_q;
      endcase
    end

    left_d  = left_q;
    right_d = right_q;
    if (pop) begin
      left_d  = {~head[31], head[30:16]};
      right_d = {~head[15], head[14:0]};
    end

    strobe_d   = tick;
    underrun_d = (tick && empty && !flush_i) || (underrun_q && !status_clr_i);
    overflow_d = (wr_en_i && full && !pop && !flush_i) || (overflow_q && !status_clr_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= CntReload;
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      left_q     <= 16'h8000;
      right_q    <= 16'h8000;
      strobe_q   <= 1'b0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      left_q     <= left_d;
      right_q    <= right_d;
      strobe_q   <= strobe_d;
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset; the level counter qualifies every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wr_data_i;
  end

  always_comb begin
    fifo_level_o  = level_q;
    fifo_full_o   = (level_q == LevelFull);
    fifo_low_o    = (level_q <= LevelLow);
    underrun_o    = underrun_q;
    overflow_o    = overflow_q;
    next_sample_o = strobe_q;
    left_data_o   = left_q;
    right_data_o  = right_q;
  end

endmodule

// File: tb/tb_audio_sample_pacer.sv
// Directed self-checking bench for audio_sample_pacer with an 8-cycle period and 16-deep FIFO.
module tb_audio_sample_pacer;

  localparam int unsigned Div = 8;
  localparam int unsigned DepthLog2 = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        flush = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic        status_clr = 1'b0;
  logic [4:0]  fifo_level;
  logic        fifo_full, fifo_low, underrun, overflow, next_sample;
  logic [15:0] left_data, right_data;

  int n_checks = 0;
  int n_errors = 0;
  int n;
  logic [31:0] saved;

  always #5 clk = ~clk;

  audio_sample_pacer #(
    .DIVIDER    (Div),
    .DEPTH_LOG2 (DepthLog2),
    .LOW_THRESH (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable_i     (enable),
    .flush_i      (flush),
    .wr_en_i      (wr_en),
    .wr_data_i    (wr_data),
    .status_clr_i (status_clr),
    .fifo_level_o (fifo_level),
    .fifo_full_o  (fifo_full),
    .fifo_low_o   (fifo_low),
    .underrun_o   (underrun),
    .overflow_o   (overflow),
    .next_sample_o(next_sample),
    .left_data_o  (left_data),
    .right_data_o (right_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge; all driving and sampling happens here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [31:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  // Counts edges until the strobe is seen, bounded so a dead DUT cannot hang the run.
  task automatic wait_strobe(output int cycles);
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (!next_sample && cycles < 64);
  endtask

  function automatic logic [31:0] stream_val(input int v);
    return {16'(v) + 16'h0100, 16'hF000 + 16'(v)};
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_left"}, 32'(left_data), 32'h8000);
    check({tag, "_right"}, 32'(right_data), 32'h8000);
    check({tag, "_strobe"}, 32'(next_sample), 32'd0);
    check({tag, "_level"}, 32'(fifo_level), 32'd0);
    check({tag, "_low"}, 32'(fifo_low), 32'd1);
    check({tag, "_full"}, 32'(fifo_full), 32'd0);
    check({tag, "_flags"}, {30'd0, underrun, overflow}, 32'd0);
  endtask

  initial begin
    #12;
    check_reset_state("por");
    rst_n = 1'b1;
    step();

    // Conversion and pacing.
    write({16'h0000, 16'hFFFF});
    write({16'h7FFF, 16'h8000});
    check("conv_level", 32'(fifo_level), 32'd2);
    enable = 1'b1;
    wait_strobe(n);
    check("conv_first_latency", 32'(n), 32'd8);
    check("conv_first_data", {left_data, right_data}, 32'h8000_7FFF);
    wait_strobe(n);
    check("conv_spacing", 32'(n), 32'd8);
    check("conv_second_data", {left_data, right_data}, 32'hFFFF_0000);
    check("conv_level_empty", 32'(fifo_level), 32'd0);
    // Reset asserted during the strobe cycle drops the strobe at once.
    rst_n = 1'b0;
    #1;
    check_reset_state("midop_rst");
    enable = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    // Underrun.
    enable = 1'b1;
    wait_strobe(n);
    check("udr_latency", 32'(n), 32'd8);
    check("udr_data", {left_data, right_data}, 32'h8000_8000);
    check("udr_flag", 32'(underrun), 32'd1);
    check("udr_no_ovf", 32'(overflow), 32'd0);
    step();
    check("udr_strobe_single", 32'(next_sample), 32'd0);
    status_clr = 1'b1;
    step();
    status_clr = 1'b0;
    check("udr_cleared", 32'(underrun), 32'd0);
    repeat (5) step();
    status_clr = 1'b1;  // coincides with the next empty tick
    step();
    status_clr = 1'b0;
    check("udr_clr_tick_strobe", 32'(next_sample), 32'd1);
    check("udr_clr_tick_wins", 32'(underrun), 32'd1);
    enable = 1'b0;
    status_clr = 1'b1;
    step();
    status_clr = 1'b0;
    check("udr_final_clear", 32'(underrun), 32'd0);

    // Overflow and full.
    for (int i = 1; i <= 17; i++) write({16'(i), 16'(i) + 16'h0100});
    check("ovf_level", 32'(fifo_level), 32'd16);
    check("ovf_full", 32'(fifo_full), 32'd1);
    check("ovf_low", 32'(fifo_low), 32'd0);
    check("ovf_flag", 32'(overflow), 32'd1);
    status_clr = 1'b1;
    step();
    status_clr = 1'b0;
    enable = 1'b1;
    repeat (7) step();
    wr_en   = 1'b1;
    wr_data = 32'hAAAA_5555;
    step();
    wr_en   = 1'b0;
    check("ovf_pop_strobe", 32'(next_sample), 32'd1);
    check("ovf_pop_data", {left_data, right_data}, 32'h8001_8101);
    check("ovf_pop_write_level", 32'(fifo_level), 32'd16);
    check("ovf_pop_write_noflag", 32'(overflow), 32'd0);
    for (int i = 2; i <= 16; i++) begin
      wait_strobe(n);
      check($sformatf("ovf_rb_spacing%0d", i), 32'(n), 32'd8);
      check($sformatf("ovf_rb_data%0d", i), {left_data, right_data},
            {16'(i) ^ 16'h8000, (16'(i) + 16'h0100) ^ 16'h8000});
    end
    wait_strobe(n);
    check("ovf_rb_last", {left_data, right_data}, 32'h2AAA_D555);
    check("ovf_rb_empty", 32'(fifo_level), 32'd0);
    check("ovf_rb_no_udr", 32'(underrun), 32'd0);
    enable = 1'b0;
    step();

    // Streaming with a write on every tick cycle, across pointer wrap.
    for (int v = 0; v < 3; v++) write(stream_val(v));
    enable = 1'b1;
    for (int k = 0; k < 37; k++) begin
      repeat (7) step();
      wr_en   = 1'b1;
      wr_data = stream_val(k + 3);
      step();
      wr_en   = 1'b0;
      check($sformatf("strm_strobe%0d", k), 32'(next_sample), 32'd1);
      check($sformatf("strm_data%0d", k), {left_data, right_data},
            stream_val(k) ^ 32'h8000_8000);
      check($sformatf("strm_level%0d", k), 32'(fifo_level), 32'd3);
    end
    for (int k = 37; k < 40; k++) begin
      wait_strobe(n);
      check($sformatf("strm_drain%0d", k), {left_data, right_data},
            stream_val(k) ^ 32'h8000_8000);
    end
    check("strm_flags", {30'd0, underrun, overflow}, 32'd0);
    enable = 1'b0;
    step();

    // Flush.
    for (int v = 0; v < 5; v++) write(32'h1111_0000 + 32'(v));
    check("fl_level5", 32'(fifo_level), 32'd5);
    saved   = {left_data, right_data};
    flush   = 1'b1;
    wr_en   = 1'b1;
    wr_data = 32'hDEAD_BEEF;
    step();
    flush   = 1'b0;
    wr_en   = 1'b0;
    check("fl_level0", 32'(fifo_level), 32'd0);
    check("fl_low", 32'(fifo_low), 32'd1);
    check("fl_outputs_kept", {left_data, right_data}, saved);
    check("fl_no_ovf", 32'(overflow), 32'd0);
    write(32'h1234_5678);
    enable = 1'b1;
    wait_strobe(n);
    check("fl_after_latency", 32'(n), 32'd8);
    check("fl_after_data", {left_data, right_data}, 32'h9234_D678);
    enable = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
